// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single async-FIFO write port between two producers: ALU results
//   (ALU_WIDTH bits, sent as two bytes, low byte first) and RegFile read data
//   (one byte). Each producer owns a one-entry holding register. A small FSM
//   drains one granted frame at a time, stalling on FIFO_FULL, so frames are
//   never interleaved and a captured frame is never lost.
//
//   Configuration macro: FIXED_PRIO_EN
//     undefined : when both holders are pending, round-robin arbitration; the
//                 pointer remembers the winner of the last contended grant.
//     defined   : when both holders are pending, ALU always wins (REG may starve).
module fifo_wr_arbiter #(
  parameter int BUS_WIDTH = 8,
  parameter int ALU_WIDTH = 2 * BUS_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ALU_WIDTH-1:0] ALU_OUT,
  input  logic                 ALU_VLD,
  output logic                 ALU_RDY,
  input  logic [BUS_WIDTH-1:0] RD_DATA,
  input  logic                 RD_VLD,
  output logic                 RD_RDY,
  input  logic                 FIFO_FULL,
  output logic [BUS_WIDTH-1:0] WR_DATA,
  output logic                 WR_INC,
  output logic                 BUSY,
  output logic                 OVERRUN
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_LO = 2'd1,
    ST_SEND_HI = 2'd2,
    ST_SEND_RD = 2'd3
  } state_t;

  state_t                 state_q,    state_d;
  logic                   alu_vld_q,  alu_vld_d;
  logic [ALU_WIDTH-1:0]   alu_data_q, alu_data_d;
  logic                   reg_vld_q,  reg_vld_d;
  logic [BUS_WIDTH-1:0]   reg_data_q, reg_data_d;
  logic                   overrun_q,  overrun_d;

  logic                   free_alu;
  logic                   free_reg;
  logic                   alu_capture;
  logic                   reg_capture;
  logic                   wr_inc_c;
  logic [BUS_WIDTH-1:0]   wr_data_c;

`ifndef FIXED_PRIO_EN
  // rr_ptr holds the winner of the most recent contended grant.
  localparam logic RR_REG = 1'b0;
  localparam logic RR_ALU = 1'b1;
  logic rr_ptr_q, rr_ptr_d;
`endif

  // Frame sequencing, arbitration and the FIFO write port.
  always_comb begin
    state_d   = state_q;
    wr_inc_c  = 1'b0;
    wr_data_c = '0;
    free_alu  = 1'b0;
    free_reg  = 1'b0;
`ifndef FIXED_PRIO_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (alu_vld_q && reg_vld_q) begin
`ifdef FIXED_PRIO_EN
          state_d = ST_SEND_LO;
`else
          if (rr_ptr_q == RR_ALU) begin
            state_d  = ST_SEND_RD;
            rr_ptr_d = RR_REG;
          end else begin
            state_d  = ST_SEND_LO;
            rr_ptr_d = RR_ALU;
          end
`endif
        end else if (alu_vld_q) begin
          state_d = ST_SEND_LO;
        end else if (reg_vld_q) begin
          state_d = ST_SEND_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_LO: begin
        wr_data_c = alu_data_q[BUS_WIDTH-1:0];
        wr_inc_c  = !FIFO_FULL;
        if (!FIFO_FULL) begin
          state_d = ST_SEND_HI;
        end else begin
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_HI: begin
        wr_data_c = alu_data_q[ALU_WIDTH-1:BUS_WIDTH];
        wr_inc_c  = !FIFO_FULL;
        if (!FIFO_FULL) begin
          state_d  = ST_IDLE;
          free_alu = 1'b1;
        end else begin
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_RD: begin
        wr_data_c = reg_data_q;
        wr_inc_c  = !FIFO_FULL;
        if (!FIFO_FULL) begin
          state_d  = ST_IDLE;
          free_reg = 1'b1;
        end else begin
          state_d = ST_SEND_RD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Holder capture/free and overrun detection; a full holder ignores new data.
  always_comb begin
    alu_capture = ALU_VLD && !alu_vld_q;
    reg_capture = RD_VLD && !reg_vld_q;

    if (alu_capture) begin
      alu_vld_d  = 1'b1;
      alu_data_d = ALU_OUT;
    end else if (free_alu) begin
      alu_vld_d  = 1'b0;
      alu_data_d = alu_data_q;
    end else begin
      alu_vld_d  = alu_vld_q;
      alu_data_d = alu_data_q;
    end

    if (reg_capture) begin
      reg_vld_d  = 1'b1;
      reg_data_d = RD_DATA;
    end else if (free_reg) begin
      reg_vld_d  = 1'b0;
      reg_data_d = reg_data_q;
    end else begin
      reg_vld_d  = reg_vld_q;
      reg_data_d = reg_data_q;
    end

    overrun_d = (ALU_VLD && alu_vld_q) || (RD_VLD && reg_vld_q);
  end

  // State register with synchronous reset; reset abandons any in-flight frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      alu_vld_q  <= 1'b0;
      alu_data_q <= '0;
      reg_vld_q  <= 1'b0;
      reg_data_q <= '0;
      overrun_q  <= 1'b0;
`ifndef FIXED_PRIO_EN
      rr_ptr_q   <= RR_REG;
`endif
    end else begin
      state_q    <= state_d;
      alu_vld_q  <= alu_vld_d;
      alu_data_q <= alu_data_d;
      reg_vld_q  <= reg_vld_d;
      reg_data_q <= reg_data_d;
      overrun_q  <= overrun_d;
`ifndef FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign ALU_RDY = !alu_vld_q;
  assign RD_RDY  = !reg_vld_q;
  assign WR_INC  = wr_inc_c;
  assign WR_DATA = wr_data_c;
  assign BUSY    = alu_vld_q || reg_vld_q || (state_q != ST_IDLE);
  assign OVERRUN = overrun_q;

endmodule
